// File: rtl/conv_pkg.sv
// conv_pkg: shared constants, kernel word count and loader state encoding for conv3d blocks
package conv_pkg;
  localparam int DATA_WIDTH = 32;
  function automatic int kwords(input int chanel);
    return 9 * chanel + 1;
  endfunction
  typedef enum logic [2:0] {IDLE, CLEAR, STREAM, WAIT_ACK, DONE} loader_state_t;
endpackage

// File: rtl/conv_kernel_loader.sv
// conv_kernel_loader: streams one filter's weights and bias from a sync-read ROM into a conv3d block
module conv_kernel_loader
  import conv_pkg::*;
#(
  parameter int CHANEL = 4,
  parameter int NUM_FILTER = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int BASE_ADDR = 0,
  parameter int TIMEOUT = 64
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic                              start,
  // one spare code so an out-of-range request can be represented and reported
  input  logic [$clog2(NUM_FILTER+1)-1:0]   filter_sel,
  output logic                              mem_rd_en,
  output logic [ADDR_WIDTH-1:0]             mem_addr,
  input  logic [DATA_WIDTH-1:0]             mem_rd_data,
  output logic                              target_resetn,
  output logic                              load_kernel,
  output logic [DATA_WIDTH-1:0]             kernel,
  input  logic                              load_kernel_done,
  output logic                              busy,
  output logic                              done,
  output logic                              error
);
  localparam int KWORDS = kwords(CHANEL);
  localparam int SW = $clog2(NUM_FILTER + 1);
  localparam int IW = $clog2(KWORDS + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  if (BASE_ADDR + NUM_FILTER * KWORDS > (1 << ADDR_WIDTH)) begin : g_addr_overflow
    $error("conv_kernel_loader: weight ROM layout exceeds ADDR_WIDTH");
  end

  loader_state_t state, state_nx;
  logic [IW-1:0] wcnt;
  logic [TW-1:0] tcnt;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [DATA_WIDTH-1:0] kernel_q;
  logic in_rst;
  logic bad_sel, accept, last_word, timed_out;

  assign bad_sel = filter_sel >= SW'(NUM_FILTER);
  assign accept = state == IDLE && start && !bad_sel;
  assign last_word = wcnt == IW'(KWORDS - 1);
  assign timed_out = tcnt == TW'(TIMEOUT - 1);

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     state_nx = accept ? CLEAR : IDLE;
      CLEAR:    state_nx = wcnt == IW'(1) ? STREAM : CLEAR;
      STREAM:   state_nx = last_word ? WAIT_ACK : STREAM;
      WAIT_ACK: state_nx = load_kernel_done ? DONE : timed_out ? IDLE : WAIT_ACK;
      default:  state_nx = IDLE;
    endcase
  end

  always_comb begin
    mem_rd_en = state == STREAM;
    mem_addr = mem_rd_en ? base_q + ADDR_WIDTH'(wcnt) : '0;
    busy = state inside {CLEAR, STREAM, WAIT_ACK};
    done = state == DONE;
    // conv block stays cleared while the loader itself is in reset
    target_resetn = !in_rst && state != CLEAR;
    kernel = load_kernel ? mem_rd_data : kernel_q;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      in_rst <= 1'b1;
      wcnt <= '0;
      tcnt <= '0;
      base_q <= '0;
      kernel_q <= '0;
      load_kernel <= 1'b0;
      error <= 1'b0;
    end else begin
      in_rst <= 1'b0;
      wcnt <= (state == CLEAR || state == STREAM) && state_nx == state ? wcnt + 1'b1 : '0;
      tcnt <= state == WAIT_ACK ? tcnt + 1'b1 : '0;
      base_q <= accept ? ADDR_WIDTH'(BASE_ADDR + 32'(filter_sel) * KWORDS) : base_q;
      kernel_q <= kernel;
      load_kernel <= mem_rd_en;
      error <= state == IDLE && start ? bad_sel
             : state == WAIT_ACK && timed_out && !load_kernel_done ? 1'b1 : error;
    end
  end
endmodule
